// File: rtl/siphash_stream_if.sv
// Handshake bundle between the SipHash streaming engine and its
// key/message producer and result consumer.
interface siphash_stream_if #(
    parameter int OUT_WIDTH = 64
);
    logic                 start;
    logic [127:0]         key;
    logic                 in_valid;
    logic                 in_ready;
    logic [63:0]          in_data;
    logic                 in_last;
    logic [2:0]           in_bytes;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 busy;

    modport master (
        output start, key, in_valid, in_data, in_last, in_bytes, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  start, key, in_valid, in_data, in_last, in_bytes, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/siphash_stream.sv
// Iterative SipHash-c-d / SipHash-c-d-128 engine: one SipRound per cycle,
// 64-bit little-endian message beats with length padding on the last beat.
module siphash_stream #(
    parameter int C_ROUNDS  = 2,
    parameter int D_ROUNDS  = 4,
    parameter int OUT_WIDTH = 64
) (
    input logic        clk,
    input logic        reset,
    siphash_stream_if.slave bus
);
    localparam int RMAX = (C_ROUNDS > D_ROUNDS + 1) ? C_ROUNDS : D_ROUNDS + 1;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [63:0] V1_INIT_XOR = (OUT_WIDTH == 128) ? 64'hee : 64'h0;
    localparam logic [63:0] FIN_XOR     = (OUT_WIDTH == 128) ? 64'hee : 64'hff;

    typedef enum logic [2:0] {IDLE, ABSORB, COMPRESS, FINAL, FINAL2, DONE} state_t;

    state_t         state_q, state_d;
    logic [63:0]    v0_q, v1_q, v2_q, v3_q;
    logic [63:0]    r0, r1, r2, r3;
    logic [63:0]    m_q, m_in, byte_mask, hash_v, hold_q;
    logic [7:0]     len_q, len_tail;
    logic           last_q;
    logic [RW-1:0]  rcnt_q;
    logic           phase_end;
    logic           in_ready_c, out_valid_c, busy_c;

    function automatic logic [63:0] rotl(input logic [63:0] x, input int unsigned n);
        return (x << n) | (x >> (64 - n));
    endfunction

    function automatic logic [255:0] sip_round(input logic [63:0] a, b, c, d);
        a = a + b; b = rotl(b, 13); b = b ^ a; a = rotl(a, 32);
        c = c + d; d = rotl(d, 16); d = d ^ c;
        a = a + d; d = rotl(d, 21); d = d ^ a;
        c = c + b; b = rotl(b, 17); b = b ^ c; c = rotl(c, 32);
        return {d, c, b, a};
    endfunction

    always_comb begin
        {r3, r2, r1, r0} = sip_round(v0_q, v1_q, v2_q, v3_q);
    end

    assign hash_v = v0_q ^ v1_q ^ v2_q ^ v3_q;

    always_comb begin
        byte_mask = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < {29'd0, bus.in_bytes}) byte_mask[8*i +: 8] = 8'hff;
        end
        len_tail = len_q + {5'd0, bus.in_bytes};
        m_in     = bus.in_last ? ((bus.in_data & byte_mask) | {len_tail, 56'd0})
                               : bus.in_data;
    end

    // Finalization phases spend D_ROUNDS round cycles plus one cycle that
    // registers the lane XOR, so the hash is taken from settled registers.
    assign phase_end = (state_q == COMPRESS) ? (rcnt_q == RW'(C_ROUNDS - 1))
                                             : (rcnt_q == RW'(D_ROUNDS));

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        busy_c      = 1'b1;
        unique case (state_q)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.start) state_d = ABSORB;
            end
            ABSORB: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) state_d = COMPRESS;
            end
            COMPRESS: if (phase_end) state_d = last_q ? FINAL : ABSORB;
            FINAL:    if (phase_end) state_d = (OUT_WIDTH == 128) ? FINAL2 : DONE;
            FINAL2:   if (phase_end) state_d = DONE;
            DONE: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v0_q   <= '0;
            v1_q   <= '0;
            v2_q   <= '0;
            v3_q   <= '0;
            m_q    <= '0;
            len_q  <= '0;
            last_q <= 1'b0;
            rcnt_q <= '0;
            hold_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.start) begin
                    v0_q   <= bus.key[63:0]   ^ 64'h736f6d6570736575;
                    v1_q   <= bus.key[127:64] ^ 64'h646f72616e646f6d ^ V1_INIT_XOR;
                    v2_q   <= bus.key[63:0]   ^ 64'h6c7967656e657261;
                    v3_q   <= bus.key[127:64] ^ 64'h7465646279746573;
                    len_q  <= '0;
                    rcnt_q <= '0;
                end
                ABSORB: if (bus.in_valid) begin
                    v3_q   <= v3_q ^ m_in;
                    m_q    <= m_in;
                    last_q <= bus.in_last;
                    rcnt_q <= '0;
                    if (!bus.in_last) len_q <= len_q + 8'd8;
                end
                COMPRESS: begin
                    v1_q <= r1;
                    v3_q <= r3;
                    if (phase_end) begin
                        v0_q   <= r0 ^ m_q;
                        v2_q   <= last_q ? (r2 ^ FIN_XOR) : r2;
                        rcnt_q <= '0;
                    end else begin
                        v0_q   <= r0;
                        v2_q   <= r2;
                        rcnt_q <= rcnt_q + RW'(1);
                    end
                end
                FINAL, FINAL2: begin
                    if (phase_end) begin
                        rcnt_q <= '0;
                        if (state_q == FINAL) begin
                            hold_q <= hash_v;
                            v1_q   <= v1_q ^ 64'hdd;
                        end
                    end else begin
                        {v3_q, v2_q, v1_q, v0_q} <= {r3, r2, r1, r0};
                        rcnt_q <= rcnt_q + RW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    if (OUT_WIDTH == 128) begin : g_out128
        logic [127:0] out_q;
        always_ff @(posedge clk) begin
            if (reset)                              out_q <= '0;
            else if (state_q == FINAL2 && phase_end) out_q <= {hash_v, hold_q};
        end
        assign bus.out_data = out_q;
    end else begin : g_out64
        assign bus.out_data = hold_q;
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.busy      = busy_c;
endmodule

// File: tb/tb_siphash_stream.sv
// Directed bench for siphash_stream: 2-4 64-bit, 2-4 128-bit and 1-3 64-bit
// instances, checked against published vectors and a behavioural SipHash model.
module tb_siphash_stream;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int sel   = 0;
    int unsigned beat_cyc = 0;

    logic         start_d, in_valid_d, in_last_d, out_ready_d;
    logic [127:0] key_d;
    logic [63:0]  in_data_d;
    logic [2:0]   in_bytes_d;
    logic [7:0]   msg_buf [0:511];

    siphash_stream_if #(.OUT_WIDTH(64))  if64 ();
    siphash_stream_if #(.OUT_WIDTH(128)) if128 ();
    siphash_stream_if #(.OUT_WIDTH(64))  if13 ();

    assign if64.start      = start_d & (sel == 0);
    assign if64.in_valid   = in_valid_d & (sel == 0);
    assign if64.out_ready  = out_ready_d & (sel == 0);
    assign if64.key        = key_d;
    assign if64.in_data    = in_data_d;
    assign if64.in_last    = in_last_d;
    assign if64.in_bytes   = in_bytes_d;
    assign if128.start     = start_d & (sel == 1);
    assign if128.in_valid  = in_valid_d & (sel == 1);
    assign if128.out_ready = out_ready_d & (sel == 1);
    assign if128.key       = key_d;
    assign if128.in_data   = in_data_d;
    assign if128.in_last   = in_last_d;
    assign if128.in_bytes  = in_bytes_d;
    assign if13.start      = start_d & (sel == 2);
    assign if13.in_valid   = in_valid_d & (sel == 2);
    assign if13.out_ready  = out_ready_d & (sel == 2);
    assign if13.key        = key_d;
    assign if13.in_data    = in_data_d;
    assign if13.in_last    = in_last_d;
    assign if13.in_bytes   = in_bytes_d;

    siphash_stream #(.C_ROUNDS(2), .D_ROUNDS(4), .OUT_WIDTH(64))
        dut64 (.clk(clk), .reset(reset), .bus(if64));
    siphash_stream #(.C_ROUNDS(2), .D_ROUNDS(4), .OUT_WIDTH(128))
        dut128 (.clk(clk), .reset(reset), .bus(if128));
    siphash_stream #(.C_ROUNDS(1), .D_ROUNDS(3), .OUT_WIDTH(64))
        dut13 (.clk(clk), .reset(reset), .bus(if13));

    logic         cur_in_ready, cur_out_valid, cur_busy;
    logic [127:0] cur_out_data;
    always_comb begin
        cur_in_ready  = if64.in_ready;
        cur_out_valid = if64.out_valid;
        cur_busy      = if64.busy;
        cur_out_data  = {64'd0, if64.out_data};
        if (sel == 1) begin
            cur_in_ready  = if128.in_ready;
            cur_out_valid = if128.out_valid;
            cur_busy      = if128.busy;
            cur_out_data  = if128.out_data;
        end else if (sel == 2) begin
            cur_in_ready  = if13.in_ready;
            cur_out_valid = if13.out_valid;
            cur_busy      = if13.busy;
            cur_out_data  = {64'd0, if13.out_data};
        end
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rol(input logic [63:0] x, input int n);
        logic [127:0] t;
        t = {x, x} << n;
        return t[127:64];
    endfunction

    function automatic logic [255:0] ref_round(input logic [255:0] s);
        logic [63:0] a, b, c, d;
        {d, c, b, a} = s;
        a += b; b = rol(b, 13) ^ a; a = rol(a, 32);
        c += d; d = rol(d, 16) ^ c;
        a += d; d = rol(d, 21) ^ a;
        c += b; b = rol(b, 17) ^ c; c = rol(c, 32);
        return {d, c, b, a};
    endfunction

    function automatic logic [127:0] ref_hash(input int c, input int d, input bit wide,
                                              input int len, input logic [127:0] k);
        logic [255:0] s;
        logic [63:0]  m, h0, h1;
        int           nfull;
        s = {k[127:64] ^ 64'h7465646279746573, k[63:0] ^ 64'h6c7967656e657261,
             k[127:64] ^ 64'h646f72616e646f6d ^ (wide ? 64'hee : 64'h0),
             k[63:0] ^ 64'h736f6d6570736575};
        nfull = len / 8;
        for (int b = 0; b <= nfull; b++) begin
            m = '0;
            if (b < nfull) begin
                for (int j = 0; j < 8; j++) m[8*j +: 8] = msg_buf[8*b + j];
            end else begin
                for (int j = 0; j < len % 8; j++) m[8*j +: 8] = msg_buf[8*b + j];
                m[63:56] = 8'(len);
            end
            s[255:192] ^= m;
            for (int r = 0; r < c; r++) s = ref_round(s);
            s[63:0] ^= m;
        end
        s[191:128] ^= (wide ? 64'hee : 64'hff);
        for (int r = 0; r < d; r++) s = ref_round(s);
        h0 = s[255:192] ^ s[191:128] ^ s[127:64] ^ s[63:0];
        if (!wide) return {64'd0, h0};
        s[127:64] ^= 64'hdd;
        for (int r = 0; r < d; r++) s = ref_round(s);
        h1 = s[255:192] ^ s[191:128] ^ s[127:64] ^ s[63:0];
        return {h1, h0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_msg(input logic [127:0] k);
        key_d   = k;
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
    endtask

    task automatic send_beat(input logic [63:0] d, input logic last, input logic [2:0] nb);
        int n = 0;
        in_data_d  = d;
        in_last_d  = last;
        in_bytes_d = nb;
        in_valid_d = 1'b1;
        while (!cur_in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cur_in_ready) check("in_ready_wait", 128'(cur_in_ready), 128'd1);
        else begin
            tick();
            beat_cyc = cyc;
        end
        in_valid_d = 1'b0;
    endtask

    task automatic send_msg(input int len, input logic [127:0] k);
        logic [63:0] d;
        start_msg(k);
        for (int b = 0; b < len / 8; b++) begin
            for (int j = 0; j < 8; j++) d[8*j +: 8] = msg_buf[8*b + j];
            send_beat(d, 1'b0, 3'd0);
        end
        for (int j = 0; j < 8; j++)
            d[8*j +: 8] = (j < len % 8) ? msg_buf[8*(len/8) + j] : 8'ha5;
        send_beat(d, 1'b1, 3'(len % 8));
    endtask

    task automatic get_result(output logic [127:0] data, output int lat);
        int n = 0;
        while (!cur_out_valid && n < 100) begin
            tick();
            n++;
        end
        if (!cur_out_valid) check("out_valid_wait", 128'(cur_out_valid), 128'd1);
        lat  = int'(cyc - beat_cyc);
        data = cur_out_data;
    endtask

    task automatic consume();
        out_ready_d = 1'b1;
        tick();
        out_ready_d = 1'b0;
        check("out_valid_drop", 128'(cur_out_valid), 128'd0);
    endtask

    localparam logic [127:0] KEY = 128'h0f0e0d0c0b0a09080706050403020100;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] res, first;
        int           lat, unstable;
        unsigned_b0: begin end
        start_d = 0; in_valid_d = 0; in_last_d = 0; out_ready_d = 0;
        key_d = '0; in_data_d = '0; in_bytes_d = '0;
        for (int i = 0; i < 512; i++) msg_buf[i] = 8'(i);
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;

        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_busy", 128'(cur_busy), 128'd0);
            check("rst_in_ready", 128'(cur_in_ready), 128'd0);
            check("rst_out_valid", 128'(cur_out_valid), 128'd0);
            check("rst_out_data", cur_out_data, 128'd0);
        end

        // empty message, 64-bit, stray data above in_bytes=0
        sel = 0;
        start_msg(KEY);
        check("absorb_ready", 128'(cur_in_ready), 128'd1);
        send_beat(64'hdeadbeefcafef00d, 1'b1, 3'd0);
        check("compress_ready_low", 128'(cur_in_ready), 128'd0);
        get_result(res, lat);
        check("empty64_hash", res, 128'h726fdb47dd0e0e31);
        check("empty64_latency", 128'(lat), 128'd7);
        consume();

        // 15-byte message, beat spacing C+1
        start_msg(KEY);
        send_beat(64'h0706050403020100, 1'b0, 3'd0);
        lat = int'(beat_cyc);
        send_beat(64'h000e0d0c0b0a0908, 1'b1, 3'd7);
        check("beat_gap", 128'(int'(beat_cyc) - lat), 128'd3);
        get_result(res, lat);
        check("msg15_hash", res, 128'ha129ca6149be45e5);
        consume();

        // 128-bit, empty message
        sel = 1;
        start_msg(KEY);
        send_beat(64'h0, 1'b1, 3'd0);
        get_result(res, lat);
        check("empty128_hash", res, {64'h930255c71472f66d, 64'he6a825ba047f81a3});
        check("empty128_latency", 128'(lat), 128'd12);
        consume();

        // backpressure with stray start/in_valid, then start during handshake
        sel = 0;
        send_msg(63, KEY);
        get_result(first, lat);
        check("msg63_hash", first, ref_hash(2, 4, 1'b0, 63, KEY));
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            start_d    = (i % 3 == 0);
            in_valid_d = (i % 2 == 0);
            tick();
            if (cur_out_valid !== 1'b1 || cur_out_data !== first) unstable++;
        end
        check("bp_stable", 128'(unstable), 128'd0);
        in_valid_d  = 1'b0;
        start_d     = 1'b1;
        out_ready_d = 1'b1;
        tick();
        start_d     = 1'b0;
        out_ready_d = 1'b0;
        check("hs_out_valid", 128'(cur_out_valid), 128'd0);
        check("hs_start_ignored", 128'(cur_busy), 128'd0);
        check("hs_in_ready", 128'(cur_in_ready), 128'd0);
        in_valid_d = 1'b1;
        tick();
        in_valid_d = 1'b0;
        check("idle_in_valid_ignored", 128'(cur_busy), 128'd0);

        // 263-byte message: length byte wraps to 0x07
        for (int i = 0; i < 512; i++) msg_buf[i] = 8'(i * 7 + 3);
        sel = 0;
        send_msg(263, KEY ^ 128'h5555);
        get_result(res, lat);
        check("wrap_2_4", res, ref_hash(2, 4, 1'b0, 263, KEY ^ 128'h5555));
        consume();
        sel = 2;
        send_msg(263, KEY ^ 128'h5555);
        get_result(res, lat);
        check("wrap_1_3", res, ref_hash(1, 3, 1'b0, 263, KEY ^ 128'h5555));
        consume();
        sel = 1;
        send_msg(263, KEY);
        get_result(res, lat);
        check("wrap_128", res, ref_hash(2, 4, 1'b1, 263, KEY));
        consume();
        sel = 2;
        send_msg(8, ~KEY);
        get_result(res, lat);
        check("len8_1_3", res, ref_hash(1, 3, 1'b0, 8, ~KEY));
        consume();

        // reset while compressing discards the message
        sel = 0;
        start_msg(KEY);
        send_beat(64'h0123456789abcdef, 1'b0, 3'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_busy", 128'(cur_busy), 128'd0);
        check("midrst_in_ready", 128'(cur_in_ready), 128'd0);
        check("midrst_out_valid", 128'(cur_out_valid), 128'd0);
        check("midrst_out_data", cur_out_data, 128'd0);
        start_msg(KEY);
        send_beat(64'h0, 1'b1, 3'd0);
        get_result(res, lat);
        check("post_rst_hash", res, 128'h726fdb47dd0e0e31);
        consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
